// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between two fetch cores and the bus data port.
// Data has priority, a starvation counter forces fetch through, and fetches alternate between cores.
module ram_arbiter #(
    parameter int IWAIT_MAX = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [1:0]       iREN,
    input  logic [1:0][31:0] iaddr,
    output logic [1:0]       iwait,
    output logic [1:0][31:0] iload,
    input  logic             dREN,
    input  logic             dWEN,
    input  logic [31:0]      daddr,
    input  logic [31:0]      dstore,
    output logic             dwait,
    output logic [31:0]      dload,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [31:0]      ramload,
    input  logic [1:0]       ramstate
);
    localparam int SW = $clog2(IWAIT_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(IWAIT_MAX);
    localparam logic [1:0] ACCESS = 2'd2;

    typedef enum logic [1:0] {IDLE, OWN_D, OWN_I0, OWN_I1} state_t;

    state_t state_q, state_d, winner, pick_i, gnt;
    logic rr_q, rr_d;
    logic [SW-1:0] starve_q, starve_d;
    logic d_req, owner_req, done;

    assign d_req = dREN | dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            starve_q <= starve_d;
        end
    end

    // Grant is IDLE while in reset so RAM enables drop the moment nRST falls.
    always_comb begin
        pick_i    = (iREN == 2'b11) ? (rr_q ? OWN_I1 : OWN_I0) : (iREN[1] ? OWN_I1 : OWN_I0);
        winner    = (|iREN && starve_q == SMAX) ? pick_i : d_req ? OWN_D : |iREN ? pick_i : IDLE;
        owner_req = state_q == OWN_D ? d_req : state_q == OWN_I0 ? iREN[0] :
                    state_q == OWN_I1 ? iREN[1] : 1'b0;
        gnt       = !nRST ? IDLE : state_q == IDLE ? winner : owner_req ? state_q : IDLE;
        done      = gnt != IDLE && ramstate == ACCESS;
        state_d   = done ? IDLE : gnt;
        rr_d      = (done && gnt != OWN_D) ? (gnt == OWN_I0) : rr_q;
        starve_d  = (done && gnt != OWN_D) ? '0 :
                    (done && |iREN && starve_q != SMAX) ? starve_q + SW'(1) : starve_q;
    end

    always_comb begin
        ramWEN   = gnt == OWN_D && dWEN;
        ramREN   = gnt == OWN_I0 || gnt == OWN_I1 || (gnt == OWN_D && !dWEN);
        ramaddr  = gnt == OWN_D ? daddr : gnt == OWN_I0 ? iaddr[0] : gnt == OWN_I1 ? iaddr[1] : '0;
        ramstore = ramWEN ? dstore : '0;
        dwait    = !(gnt == OWN_D && ramstate == ACCESS);
        dload    = gnt == OWN_D ? ramload : '0;
        iwait[0] = !(gnt == OWN_I0 && ramstate == ACCESS);
        iwait[1] = !(gnt == OWN_I1 && ramstate == ACCESS);
        iload[0] = gnt == OWN_I0 ? ramload : '0;
        iload[1] = gnt == OWN_I1 ? ramload : '0;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: requester agents and a latency-programmable RAM model around ram_arbiter,
// with completions checked in order against a scoreboard of expected transactions.
module tb_ram_arbiter;
    typedef struct {int who; logic [31:0] addr; logic wr; logic [31:0] data;} exp_t;
    typedef struct {logic [31:0] addr; logic wr; logic [31:0] data;} dreq_t;

    logic             CLK, nRST;
    logic [1:0]       iREN, iwait;
    logic [1:0][31:0] iaddr, iload;
    logic             dREN, dWEN, dwait, ramREN, ramWEN;
    logic [31:0]      daddr, dstore, dload, ramaddr, ramstore, ramload;
    logic [1:0]       ramstate;

    int n_chk = 0, n_pass = 0;
    int lat = 2, cnt;
    exp_t sb[$];
    dreq_t dq[$];
    logic [31:0] iq0[$], iq1[$];
    logic done_d = 0, done_i0 = 0, done_i1 = 0;

    ram_arbiter #(.IWAIT_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] memval(logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // RAM answers ACCESS once the request has been held for lat cycles.
    assign ramload  = memval(ramaddr);
    assign ramstate = (ramREN | ramWEN) ? (cnt >= lat ? 2'd2 : 2'd1) : 2'd0;
    always @(posedge CLK or negedge nRST)
        if (!nRST) cnt <= 0;
        else cnt <= ((ramREN | ramWEN) && ramstate != 2'd2) ? cnt + 1 : 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    task automatic drive();
        iREN     = {iq1.size() != 0, iq0.size() != 0};
        iaddr[0] = iq0.size() != 0 ? iq0[0] : 32'h0;
        iaddr[1] = iq1.size() != 0 ? iq1[0] : 32'h0;
        dREN     = dq.size() != 0;
        dWEN     = dq.size() != 0 && dq[0].wr;
        daddr    = dq.size() != 0 ? dq[0].addr : 32'h0;
        dstore   = dq.size() != 0 ? dq[0].data : 32'h0;
    endtask

    task automatic req_i(int c, logic [31:0] a);
        if (c == 0) iq0.push_back(a); else iq1.push_back(a);
        sb.push_back('{c + 1, a, 1'b0, memval(a)});
        drive();
    endtask

    task automatic req_d(logic [31:0] a, logic wr, logic [31:0] d);
        dq.push_back('{a, wr, d});
        sb.push_back('{0, a, wr, wr ? d : memval(a)});
        drive();
    endtask

    task automatic complete(int who, logic [31:0] got_addr, logic [31:0] got_load);
        exp_t e;
        e = sb.size() != 0 ? sb.pop_front() : '{-1, 32'h0, 1'b0, 32'h0};
        check("who", 32'(who), 32'(e.who));
        check("ramaddr", got_addr, e.addr);
        if (e.wr) begin
            check("ramWEN", 32'(ramWEN), 32'd1);
            check("ramREN", 32'(ramREN), 32'd0);
            check("ramstore", ramstore, e.data);
        end else check("load", got_load, e.data);
    endtask

    task automatic monitor();
        check("wait_vs_access", 32'(!(&{iwait, dwait})), 32'((ramREN | ramWEN) && ramstate == 2'd2));
        if (!dwait) begin complete(0, ramaddr, dload); done_d = 1; end
        if (!iwait[0]) begin complete(1, ramaddr, iload[0]); done_i0 = 1; end
        if (!iwait[1]) begin complete(2, ramaddr, iload[1]); done_i1 = 1; end
    endtask

    task automatic cycle();
        @(negedge CLK);
        monitor();
        @(posedge CLK);
        #1;
        if (done_d) void'(dq.pop_front());
        if (done_i0) void'(iq0.pop_front());
        if (done_i1) void'(iq1.pop_front());
        {done_d, done_i0, done_i1} = 3'b000;
        drive();
    endtask

    task automatic run(string tag, int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin cycle(); n++; end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic idle_checks(string tag);
        check({tag, "_iwait"}, 32'(iwait), 32'd3);
        check({tag, "_dwait"}, 32'(dwait), 32'd1);
        check({tag, "_ramen"}, 32'({ramREN, ramWEN}), 32'd0);
        check({tag, "_ramaddr"}, ramaddr, 32'd0);
        check({tag, "_loads"}, dload | iload[0] | iload[1], 32'd0);
    endtask

    initial begin
        nRST = 0;
        drive();
        repeat (2) @(posedge CLK);
        #1;
        idle_checks("reset");
        nRST = 1;
        cycle();
        idle_checks("post_reset");

        lat = 2;
        req_i(0, 32'h100); req_i(1, 32'h200); req_i(0, 32'h104); req_i(1, 32'h204);
        run("rr_drain", 40);

        req_i(0, 32'h300);
        cycle();
        req_d(32'h40, 1'b0, 32'h0);
        #2;
        check("hold_ramaddr", ramaddr, 32'h300);
        check("hold_dwait", 32'(dwait), 32'd1);
        run("nopreempt_drain", 20);

        req_d(32'h80, 1'b1, 32'hDEADBEEF);
        #2;
        check("wr_ramWEN", 32'(ramWEN), 32'd1);
        check("wr_ramREN", 32'(ramREN), 32'd0);
        run("write_drain", 20);

        lat = 0;
        for (int k = 0; k < 4; k++) req_d(32'h1000 + 32'(4 * k), 1'b0, 32'h0);
        req_i(0, 32'h900);
        for (int k = 4; k < 6; k++) req_d(32'h1000 + 32'(4 * k), 1'b0, 32'h0);
        run("starve_drain", 20);
        check("starve_agents", 32'(dq.size() + iq0.size()), 32'd0);

        lat = 5;
        req_d(32'h500, 1'b0, 32'h0);
        repeat (2) cycle();
        check("pre_rst_ramREN", 32'(ramREN), 32'd1);
        nRST = 0;
        #1;
        check("rst_ramen", 32'({ramREN, ramWEN}), 32'd0);
        check("rst_dwait", 32'(dwait), 32'd1);
        repeat (2) cycle();
        nRST = 1;
        lat = 2;
        req_i(0, 32'h600);
        req_i(1, 32'h700);
        run("post_rst_drain", 40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
